// File: rtl/icache_fetch.sv
// Instruction fetch front-end sitting between a core's ROM port and a single-beat read bus.
//
// Two implementations, selected at compile time by the ICACHE_EN macro:
//   ICACHE_EN defined   : direct-mapped cache of LINES one-word lines.
//   ICACHE_EN undefined : single-entry buffer (one valid/address/word register), LINES unused.
// Both share the same two-state controller (IDLE / REFILL) and external behaviour.
//
// Ports
//   clk         in   1  clock, all state on the rising edge
//   rst         in   1  asynchronous reset, active low
//   cpu_ce_i    in   1  core fetch enable
//   cpu_addr_i  in  32  fetch address, bits [1:0] ignored
//   cpu_inst_o  out 32  instruction to the core (zero unless a hit is delivered)
//   stall_o     out  1  requested instruction not available this cycle
//   flush_i     in   1  invalidate all lines at the next edge
//   bus_req_o   out  1  memory read request, high only in REFILL
//   bus_addr_o  out 32  word-aligned read address
//   bus_ack_i   in   1  single-cycle read completion
//   bus_data_i  in  32  read data, valid with bus_ack_i

module icache_fetch #(
    parameter int unsigned LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_inst_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]  state_q, state_d;
    // Word address (addr[31:2]) of the line being refilled.
    logic [29:0] addr_q, addr_d;

    logic        lookup_hit;   // storage holds the word for cpu_addr_i
    logic [31:0] lookup_word;  // stored word for cpu_addr_i (meaningful only on a hit)
    logic        fill_en;      // refill data is accepted this cycle
    logic        hit_now;      // hit actually delivered to the core

    // Byte offset bits are never needed by a word-granular fetch path.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    assign fill_en = (state_q == REFILL) && bus_ack_i;

`ifdef ICACHE_EN

    localparam int unsigned IdxW = $clog2(LINES);
    localparam int unsigned TagW = 30 - IdxW;

    logic [IdxW-1:0]  req_idx;
    logic [TagW-1:0]  req_tag;
    logic [IdxW-1:0]  fill_idx;
    logic [TagW-1:0]  fill_tag;

    logic [LINES-1:0] valid_q;
    logic [TagW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign req_idx  = cpu_addr_i[IdxW+1:2];
    assign req_tag  = cpu_addr_i[31:IdxW+2];
    assign fill_idx = addr_q[IdxW-1:0];
    assign fill_tag = addr_q[29:IdxW];

    // Flush has priority over a coincident fill so the refilled line stays invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus_data_i;
        end
    end

    assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lookup_word = data_q[req_idx];

`else

    logic        buf_valid_q;
    logic [29:0] buf_addr_q;
    logic [31:0] buf_data_q;

    // Line count has no meaning for the single-entry buffer.
    localparam int unsigned unused_lines = LINES;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
        end else if (flush_i) begin
            buf_valid_q <= 1'b0;
        end else if (fill_en) begin
            buf_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            buf_addr_q <= addr_q;
            buf_data_q <= bus_data_i;
        end
    end

    assign lookup_hit  = buf_valid_q && (buf_addr_q == cpu_addr_i[31:2]);
    assign lookup_word = buf_data_q;

`endif

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------

    assign hit_now = (state_q == IDLE) && cpu_ce_i && lookup_hit;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Acks arriving here are stale and deliberately ignored.
                if (cpu_ce_i && !lookup_hit) begin
                    state_d = REFILL;
                    addr_d  = cpu_addr_i[31:2];
                end
            end
            REFILL: begin
                // Address changes from the core are ignored until the refill lands.
                if (bus_ack_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // A disabled core sees neither stall nor data, even while a refill drains.
    assign stall_o    = cpu_ce_i && !hit_now;
    assign cpu_inst_o = hit_now ? lookup_word : 32'h0;
    assign bus_req_o  = (state_q == REFILL);
    assign bus_addr_o = (state_q == REFILL) ? {addr_q, 2'b00} : 32'h0;

endmodule

// File: tb/tb_icache_fetch.sv
// Randomised scoreboard bench for icache_fetch. Expected bus addresses and delivered
// instructions are predicted from a line-indexed model (one entry when ICACHE_EN is
// undefined) and checked by an independent monitor sampling on the falling edge.

module tb_icache_fetch;

    localparam int unsigned LINES = 16;
`ifdef ICACHE_EN
    localparam int unsigned MODEL_N = LINES;
`else
    localparam int unsigned MODEL_N = 1;
`endif

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_inst_o;
    logic        stall_o;
    logic        flush_i;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_data_i;

    icache_fetch #(.LINES(LINES)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_inst_o (cpu_inst_o),
        .stall_o    (stall_o),
        .flush_i    (flush_i),
        .bus_req_o  (bus_req_o),
        .bus_addr_o (bus_addr_o),
        .bus_ack_i  (bus_ack_i),
        .bus_data_i (bus_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t        inst_q[$];
    logic [31:0] bus_q[$];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: entry = word address mod N, tag = word address div N.
    bit          m_valid [MODEL_N];
    int unsigned m_tag   [MODEL_N];

    int slave_delay  = 0;
    int slave_cnt    = 0;
    bit flush_on_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: got event want none at %0t", name, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_1234;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int unsigned w;
        w = {2'b00, a[31:2]};
        return m_valid[w % MODEL_N] && (m_tag[w % MODEL_N] == w / MODEL_N);
    endfunction

    task automatic m_fill(input logic [31:0] a);
        int unsigned w;
        w = {2'b00, a[31:2]};
        m_valid[w % MODEL_N] = 1'b1;
        m_tag[w % MODEL_N]   = w / MODEL_N;
    endtask

    task automatic m_flush();
        for (int i = 0; i < int'(MODEL_N); i++) m_valid[i] = 1'b0;
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge. Also acts as
    // the memory slave: ack slave_delay cycles after the request rises.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_ack_i  = 1'b0;
        flush_i    = 1'b0;
        bus_data_i = 32'h0;
        if (bus_req_o) begin
            if (slave_cnt >= slave_delay) begin
                bus_ack_i  = 1'b1;
                bus_data_i = mem_word(bus_addr_o);
                if (flush_on_ack) begin
                    flush_i      = 1'b1;
                    flush_on_ack = 1'b0;
                end
                slave_cnt = 0;
            end else begin
                slave_cnt++;
            end
        end else begin
            slave_cnt = 0;
        end
    endtask

    task automatic wait_served();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!stall_o) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) fail_now("fetch_timeout");
        tick();
    endtask

    task automatic fetch(input logic [31:0] a, input bit fl);
        exp_t e;
        int   d;
        d = slave_delay;
        if (m_hit(a)) begin
            e.stalls = 0;
        end else begin
            bus_q.push_back({a[31:2], 2'b00});
            if (fl) begin
                bus_q.push_back({a[31:2], 2'b00});
                m_flush();
                flush_on_ack = 1'b1;
                e.stalls = 2 * (d + 2);
            end else begin
                e.stalls = d + 2;
            end
            m_fill(a);
        end
        e.data = mem_word(a);
        inst_q.push_back(e);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = a;
        wait_served();
    endtask

    // a must miss; the core moves to b one cycle into the refill of a.
    task automatic fetch_switch(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   d;
        d = slave_delay;
        bus_q.push_back({a[31:2], 2'b00});
        m_fill(a);
        e.stalls = d + 2;
        if (!m_hit(b)) begin
            bus_q.push_back({b[31:2], 2'b00});
            m_fill(b);
            e.stalls += d + 2;
        end
        e.data = mem_word(b);
        inst_q.push_back(e);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = a;
        @(negedge clk);
        tick();
        cpu_addr_i = b;
        wait_served();
    endtask

    task automatic flush_cycle();
        cpu_ce_i = 1'b0;
        flush_i  = 1'b1;
        m_flush();
        tick();
    endtask

    task automatic idle_cycle(input bit stray_ack);
        cpu_ce_i   = 1'b0;
        cpu_addr_i = $urandom;
        if (stray_ack) begin
            bus_ack_i  = 1'b1;
            bus_data_i = $urandom;
        end
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        bit   prev_req;
        int   stall_cnt;
        exp_t e;
        prev_req  = 1'b0;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req  = 1'b0;
                stall_cnt = 0;
            end else begin
                if (bus_req_o && !prev_req) begin
                    if (bus_q.size() == 0) fail_now("unexpected_bus_req");
                    else check("bus_addr", bus_addr_o, bus_q.pop_front());
                end
                if (cpu_ce_i) begin
                    if (stall_o) begin
                        stall_cnt++;
                        check("inst_zero_while_stalled", cpu_inst_o, 32'h0);
                    end else if (inst_q.size() == 0) begin
                        fail_now("unexpected_delivery");
                        stall_cnt = 0;
                    end else begin
                        e = inst_q.pop_front();
                        check("inst_data", cpu_inst_o, e.data);
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                        stall_cnt = 0;
                    end
                end else begin
                    check("ce0_stall", {31'h0, stall_o}, 32'h0);
                    check("ce0_inst", cpu_inst_o, 32'h0);
                end
                prev_req = bus_req_o;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] last;
        int          r;

        rst        = 1'b1;
        cpu_ce_i   = 1'b0;
        cpu_addr_i = 32'h0;
        flush_i    = 1'b0;
        bus_ack_i  = 1'b0;
        bus_data_i = 32'h0;
        m_flush();
        #1 rst = 1'b0;

        // Outputs while held in reset.
        #2;
        check("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
        check("rst_bus_addr", bus_addr_o, 32'h0);
        check("rst_stall_ce0", {31'h0, stall_o}, 32'h0);
        check("rst_inst_ce0", cpu_inst_o, 32'h0);
        cpu_ce_i = 1'b1;
        #1;
        check("rst_stall_ce1", {31'h0, stall_o}, 32'h1);
        check("rst_inst_ce1", cpu_inst_o, 32'h0);
        cpu_ce_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Cold fetch of 0x0 with ack three cycles after the request rises.
        slave_delay = 3;
        fetch(32'h0, 1'b0);

        // Fill sixteen sequential words, then fetch them again.
        slave_delay = 1;
        for (int i = 0; i < 16; i++) fetch(32'(i * 4), 1'b0);
        for (int i = 0; i < 16; i++) fetch(32'(i * 4), 1'b0);

        // Same index, different tag.
        fetch(32'h0, 1'b0);
        fetch(32'h40, 1'b0);
        fetch(32'h0, 1'b0);

        // Flush coincident with the refill ack.
        flush_cycle();
        slave_delay = 2;
        fetch(32'h8, 1'b1);
        fetch(32'h8, 1'b0);

        // Core changes address mid-refill.
        flush_cycle();
        fetch_switch(32'h100, 32'h104);
        fetch_switch(32'h200, 32'h200);

        // Single-entry style sequence.
        flush_cycle();
        fetch(32'h4, 1'b0);
        fetch(32'h8, 1'b0);
        fetch(32'h4, 1'b0);
        fetch(32'h4, 1'b0);

        // Stray ack while idle must not disturb stored data.
        idle_cycle(1'b1);
        fetch(32'h4, 1'b0);

        // Reset during a refill; a late ack afterwards is ignored.
        flush_cycle();
        slave_delay = 20;
        bus_q.push_back(32'h0);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("refill_req", {31'h0, bus_req_o}, 32'h1);
        check("refill_stall", {31'h0, stall_o}, 32'h1);
        check("refill_inst", cpu_inst_o, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("midrst_bus_req", {31'h0, bus_req_o}, 32'h0);
        check("midrst_bus_addr", bus_addr_o, 32'h0);
        check("midrst_stall", {31'h0, stall_o}, 32'h1);
        m_flush();
        cpu_ce_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hDEAD_BEEF;
        tick();
        slave_delay = 2;
        fetch(32'h0, 1'b0);

        // Randomised traffic.
        last = 32'h0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 11);
            a = 32'($urandom_range(0, 47) * 4);
            if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
            a[1:0] = 2'($urandom);
            slave_delay = $urandom_range(0, 4);
            if (r == 0) begin
                flush_cycle();
            end else if (r == 1) begin
                idle_cycle(1'b1);
            end else if (r == 2) begin
                idle_cycle(1'b0);
            end else if (r == 3 && !m_hit(a)) begin
                b = ($urandom_range(0, 1) != 0) ? last : 32'($urandom_range(0, 47) * 4);
                fetch_switch(a, b);
                last = b;
            end else begin
                if ($urandom_range(0, 1) != 0) a = {last[31:2], 2'($urandom)};
                fetch(a, 1'b0);
                last = a;
            end
        end

        cpu_ce_i = 1'b0;
        tick();
        tick();
        check("bus_q_left", 32'(bus_q.size()), 32'h0);
        check("inst_q_left", 32'(inst_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
